// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the XM23 instruction fetch unit.
package instruction_fetch_pkg;

    localparam int unsigned XM23_INSTR_W = 16;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned WAIT_W       = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Captured instruction together with the address it came from.
    typedef struct packed {
        logic [XM23_INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]       pc;
    } fetch_word_t;

    // Instructions are word aligned; an odd fetch address is a fault.
    function automatic fetch_state_t entry_state(input logic [ADDR_W-1:0] addr);
        return addr[0] ? ST_FAULT : ST_REQ;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts memory wait cycles of one read; expire_c flags the last allowed wait cycle.
module fetch_timeout_counter
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign expire_c = enable && (count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch.sv
// XM23 instruction fetch: reads one word per instruction and hands it to the decoder with a one-cycle E strobe.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic [ADDR_W-1:0]       target,
    input  logic                    stall,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    input  logic [XM23_INSTR_W-1:0] mem_data,
    output logic [XM23_INSTR_W-1:0] instr,
    output logic                    e,
    output logic [ADDR_W-1:0]       instr_pc,
    output logic                    flt
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    fetch_word_t       fetched;
    logic              capture;
    logic              e_next, flt_next, mem_rd_next;
    logic              wait_en, wait_clear, wait_expire;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .enable   (wait_en),
        .expire_c (wait_expire)
    );

    // Only cycles with an outstanding read count toward the timeout.
    assign wait_en    = (state == ST_REQ) && mem_rd && !mem_ready;
    assign wait_clear = (state != ST_REQ) || (state_next != ST_REQ) || branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        unique case (state)
            ST_REQ: begin
                if (branch) begin
                    pc_next    = target;
                    state_next = entry_state(target);
                end else if (pc[0]) begin
                    state_next = ST_FAULT;
                end else if (mem_rd && mem_ready) begin
                    capture    = 1'b1;
                    pc_next    = pc + ADDR_W'(2);
                    state_next = ST_ISSUE;
                end else if (wait_expire) begin
                    state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (branch) begin
                    pc_next    = target;
                    state_next = entry_state(target);
                end else if (e) begin
                    state_next = entry_state(pc);
                end
            end
            ST_FAULT: begin
                if (branch && !target[0]) begin
                    pc_next    = target;
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // E is decided one edge ahead using the stall sampled at that edge; a branch always cancels it.
    always_comb begin
        e_next      = 1'b0;
        flt_next    = 1'b0;
        mem_rd_next = 1'b0;
        if (!branch && !stall) begin
            e_next = capture || ((state == ST_ISSUE) && !e);
        end
        flt_next = (state_next == ST_FAULT);
        // A redirect leaves one idle cycle so the address never moves under an active read.
        mem_rd_next = (state_next == ST_REQ) && !branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            fetched <= '0;
            e       <= 1'b0;
            flt     <= 1'b0;
            mem_rd  <= 1'b0;
        end else begin
            pc     <= pc_next;
            e      <= e_next;
            flt    <= flt_next;
            mem_rd <= mem_rd_next;
            if (capture) begin
                fetched <= '{instr: mem_data, pc: pc};
            end
        end
    end

    assign mem_addr = pc;
    assign instr    = fetched.instr;
    assign instr_pc = fetched.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [15:0] target;
    logic        stall;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        e;
    logic [15:0] instr_pc;
    logic        flt;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .branch    (branch),
        .target    (target),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .instr     (instr),
        .e         (e),
        .instr_pc  (instr_pc),
        .flt       (flt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        branch    = 1'b0;
        target    = 16'h0000;
        stall     = 1'b0;
        mem_ready = 1'b0;
        mem_data  = 16'h0000;
        tick();
        tick();

        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_e", 32'(e), 32'h0);
        check("rst_flt", 32'(flt), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);

        // First fetch, zero-wait
        rst_n = 1'b1;
        tick();
        check("first_mem_rd", 32'(mem_rd), 32'h1);
        check("first_mem_addr", 32'(mem_addr), 32'h0000);
        mem_ready = 1'b1;
        mem_data  = 16'h4C01;
        tick();
        mem_ready = 1'b0;
        check("first_e", 32'(e), 32'h1);
        check("first_instr", 32'(instr), 32'h4C01);
        check("first_instr_pc", 32'(instr_pc), 32'h0000);
        check("first_rd_low", 32'(mem_rd), 32'h0);
        tick();
        check("first_e_single", 32'(e), 32'h0);
        check("second_mem_rd", 32'(mem_rd), 32'h1);
        check("second_mem_addr", 32'(mem_addr), 32'h0002);

        // Stall for three cycles around the capture
        stall     = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 16'h1234;
        tick();
        mem_ready = 1'b0;
        check("stall_instr", 32'(instr), 32'h1234);
        check("stall_instr_pc", 32'(instr_pc), 32'h0002);
        for (int i = 0; i < 2; i++) begin
            check("stall_e", 32'(e), 32'h0);
            check("stall_rd", 32'(mem_rd), 32'h0);
            tick();
        end
        check("stall_e_last", 32'(e), 32'h0);
        check("stall_rd_last", 32'(mem_rd), 32'h0);
        stall = 1'b0;
        tick();
        check("stall_e_pulse", 32'(e), 32'h1);
        check("stall_instr_held", 32'(instr), 32'h1234);
        check("stall_rd_during_e", 32'(mem_rd), 32'h0);
        tick();
        check("stall_e_single", 32'(e), 32'h0);
        check("stall_next_addr", 32'(mem_addr), 32'h0004);
        check("stall_next_rd", 32'(mem_rd), 32'h1);

        // Branch in the same cycle as data: data dropped
        mem_ready = 1'b1;
        mem_data  = 16'hDEAD;
        branch    = 1'b1;
        target    = 16'h0100;
        tick();
        branch    = 1'b0;
        mem_ready = 1'b0;
        check("br_no_e", 32'(e), 32'h0);
        check("br_instr_kept", 32'(instr), 32'h1234);
        check("br_addr", 32'(mem_addr), 32'h0100);
        check("br_bubble", 32'(mem_rd), 32'h0);
        tick();
        check("br_rd", 32'(mem_rd), 32'h1);
        check("br_addr_rd", 32'(mem_addr), 32'h0100);
        check("br_no_e_late", 32'(e), 32'h0);

        // Bus timeout
        n = 0;
        while (!flt && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd15);
        check("to_flt", 32'(flt), 32'h1);
        check("to_rd", 32'(mem_rd), 32'h0);
        tick();
        check("to_flt_hold", 32'(flt), 32'h1);
        check("to_rd_hold", 32'(mem_rd), 32'h0);
        branch = 1'b1;
        target = 16'h0200;
        tick();
        branch = 1'b0;
        check("to_exit_flt", 32'(flt), 32'h0);
        check("to_exit_addr", 32'(mem_addr), 32'h0200);
        tick();
        check("to_exit_rd", 32'(mem_rd), 32'h1);

        // Odd branch target faults without a read
        branch = 1'b1;
        target = 16'h0101;
        tick();
        branch = 1'b0;
        check("odd_flt", 32'(flt), 32'h1);
        check("odd_rd", 32'(mem_rd), 32'h0);
        tick();
        tick();
        check("odd_rd_hold", 32'(mem_rd), 32'h0);
        check("odd_flt_hold", 32'(flt), 32'h1);
        branch = 1'b1;
        target = 16'h0103;
        tick();
        branch = 1'b0;
        check("odd_exit_refused", 32'(flt), 32'h1);

        // Fetch at 0xFFFE wraps to 0x0000
        branch = 1'b1;
        target = 16'hFFFE;
        tick();
        branch = 1'b0;
        check("wrap_flt_clear", 32'(flt), 32'h0);
        tick();
        check("wrap_rd", 32'(mem_rd), 32'h1);
        check("wrap_addr", 32'(mem_addr), 32'hFFFE);
        mem_ready = 1'b1;
        mem_data  = 16'hABCD;
        tick();
        mem_ready = 1'b0;
        check("wrap_e", 32'(e), 32'h1);
        check("wrap_instr", 32'(instr), 32'hABCD);
        check("wrap_instr_pc", 32'(instr_pc), 32'hFFFE);
        tick();
        check("wrap_next_addr", 32'(mem_addr), 32'h0000);
        check("wrap_next_rd", 32'(mem_rd), 32'h1);

        // Reset while a stalled instruction waits in ISSUE
        stall     = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 16'h5555;
        tick();
        mem_ready = 1'b0;
        check("rs_pending_instr", 32'(instr), 32'h5555);
        check("rs_pending_addr", 32'(mem_addr), 32'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_instr", 32'(instr), 32'h0);
        check("rs_instr_pc", 32'(instr_pc), 32'h0);
        check("rs_addr", 32'(mem_addr), 32'h0000);
        check("rs_e", 32'(e), 32'h0);
        check("rs_rd", 32'(mem_rd), 32'h0);
        check("rs_flt", 32'(flt), 32'h0);
        stall = 1'b0;
        tick();
        check("rs_e_hold", 32'(e), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rs_release_rd", 32'(mem_rd), 32'h1);
        check("rs_release_e", 32'(e), 32'h0);
        check("rs_release_addr", 32'(mem_addr), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
